// File: rtl/nrf_spi_slave.sv
// nRF24L01-style SPI responder: synchronizes sck/csn/mosi onto clk_50, decodes commands, holds a small register file.
// Optional macro NRF_SLV_ERR_CNT_EN adds the err_cnt output (aborted / ignored transaction counter).
module nrf_spi_slave #(
  parameter int NUM_REGS    = 8,
  parameter int STATUS_ADDR = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  input  logic       ce,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] rx_load,
  input  logic       rx_load_en,
  output logic [7:0] payload_out,
  output logic       payload_valid,
  output logic [7:0] cfg_out,
`ifdef NRF_SLV_ERR_CNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       busy
);

  // state  | meaning
  // IDLE   | csn high, nothing in flight
  // CMD    | shifting in the command byte, STATUS shifting out
  // DATA   | recognised command, data bytes flowing
  // IGNORE | unknown command, miso held low, no side effects
  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_IGNORE} state_t;
  typedef enum logic [2:0] {C_RREG, C_WREG, C_WTX, C_RRX, C_NOP} cmd_t;

  localparam logic [5:0] NUM_REGS_L = 6'(NUM_REGS);

  logic [SYNC_STAGES-1:0] sck_s, csn_s, mosi_s, ce_s;
  logic sck_rise, sck_fall, csn_fall, csn_rise, csn_q, mosi_bit, ce_q;

  state_t     state_q, state_n;
  cmd_t       cmd_q, dec_cmd;
  logic       dec_ok;
  logic [4:0] addr_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift_in, shift_out, in_byte;
  logic       miso_r, data_seen;
  logic [7:0] regs [NUM_REGS];
  logic [7:0] rx_buf, status_q, status_n, rd_val, next_out;
  logic       byte_done, first_data, addr_hit, wr_reg, wr_status, wr_tx, rx_clr;

  always_ff @(posedge clk_50) begin
    if (!rst) begin
      sck_s  <= '0;
      csn_s  <= '1;
      mosi_s <= '0;
      ce_s   <= '0;
    end else begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
      csn_s  <= {csn_s[SYNC_STAGES-2:0], csn};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      ce_s   <= {ce_s[SYNC_STAGES-2:0], ce};
    end
  end

  assign sck_rise = sck_s[SYNC_STAGES-2] & ~sck_s[SYNC_STAGES-1];
  assign sck_fall = ~sck_s[SYNC_STAGES-2] & sck_s[SYNC_STAGES-1];
  assign csn_fall = ~csn_s[SYNC_STAGES-2] & csn_s[SYNC_STAGES-1];
  assign csn_rise = csn_s[SYNC_STAGES-2] & ~csn_s[SYNC_STAGES-1];
  assign csn_q    = csn_s[SYNC_STAGES-1];
  assign mosi_bit = mosi_s[SYNC_STAGES-1];
  assign ce_q     = ce_s[SYNC_STAGES-1];

  assign in_byte   = {shift_in[6:0], mosi_bit};
  assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state_q != S_IDLE);
  assign status_q  = regs[STATUS_ADDR];

  always_comb begin
    dec_ok  = 1'b1;
    dec_cmd = C_NOP;
    if (in_byte[7:5] == 3'b000)      dec_cmd = C_RREG;
    else if (in_byte[7:5] == 3'b001) dec_cmd = C_WREG;
    else if (in_byte == 8'hA0)       dec_cmd = C_WTX;
    else if (in_byte == 8'h61)       dec_cmd = C_RRX;
    else if (in_byte == 8'hFF)       dec_cmd = C_NOP;
    else                             dec_ok  = 1'b0;
  end

  always_ff @(posedge clk_50) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (csn_rise) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (csn_fall) state_n = S_CMD;
        S_CMD:   if (byte_done) state_n = dec_ok ? S_DATA : S_IGNORE;
        default: state_n = state_q;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE);

  // Only the first data byte of a write-type command has side effects.
  assign first_data = byte_done && (state_q == S_DATA) && !data_seen;
  assign addr_hit   = ({1'b0, addr_q} < NUM_REGS_L);
  assign wr_reg     = first_data && (cmd_q == C_WREG) && addr_hit;
  assign wr_status  = wr_reg && (addr_q == 5'(STATUS_ADDR));
  assign wr_tx      = first_data && (cmd_q == C_WTX);
  assign rx_clr     = csn_rise && (state_q == S_DATA) && (cmd_q == C_RRX) && data_seen;

  // rx_load_en is applied last so a new payload's RX_DR beats any clear.
  always_comb begin
    status_n = status_q;
    if (wr_status)  status_n[6:4] = status_q[6:4] & ~in_byte[6:4];
    if (wr_tx)      status_n[5]   = 1'b1;
    if (rx_clr)     status_n[6]   = 1'b0;
    if (rx_load_en) status_n[6]   = 1'b1;
  end

  always_comb begin
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_q == 5'(i)) rd_val = regs[i];
  end

  always_comb begin
    next_out = 8'h00;
    if (state_q == S_DATA && cmd_q == C_RREG)     next_out = rd_val;
    else if (state_q == S_DATA && cmd_q == C_RRX) next_out = rx_buf;
  end

  always_ff @(posedge clk_50) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst)                             regs[i] <= (i == STATUS_ADDR) ? 8'h0E : 8'h00;
      else if (i == STATUS_ADDR)            regs[i] <= status_n;
      else if (wr_reg && addr_q == 5'(i))   regs[i] <= in_byte;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst) begin
      bit_cnt       <= 3'd0;
      shift_in      <= 8'h00;
      shift_out     <= 8'h00;
      miso_r        <= 1'b0;
      data_seen     <= 1'b0;
      cmd_q         <= C_NOP;
      addr_q        <= 5'd0;
      rx_buf        <= 8'h00;
      payload_out   <= 8'h00;
      payload_valid <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      if (csn_fall) begin
        bit_cnt   <= 3'd0;
        shift_in  <= 8'h00;
        data_seen <= 1'b0;
        shift_out <= {status_q[6:0], 1'b0};
        miso_r    <= status_q[7];
      end else if (csn_q) begin
        miso_r <= 1'b0;
      end else begin
        if (sck_rise && state_q != S_IDLE) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= in_byte;
        end
        // bit_cnt == 0 on a falling edge means a byte just finished: load the next one.
        if (sck_fall && state_q != S_IDLE) begin
          if (state_q == S_IGNORE) begin
            miso_r <= 1'b0;
          end else if (bit_cnt == 3'd0) begin
            miso_r    <= next_out[7];
            shift_out <= {next_out[6:0], 1'b0};
          end else begin
            miso_r    <= shift_out[7];
            shift_out <= {shift_out[6:0], 1'b0};
          end
        end
        if (byte_done && state_q == S_CMD) begin
          cmd_q  <= dec_cmd;
          addr_q <= in_byte[4:0];
        end
        if (byte_done && state_q == S_DATA) data_seen <= 1'b1;
      end
      if (wr_tx) begin
        payload_out   <= in_byte;
        payload_valid <= ce_q;
      end
      if (rx_load_en) rx_buf <= rx_load;
    end
  end

  assign miso    = miso_r & ~csn_q;
  assign miso_oe = ~csn_q;
  assign cfg_out = regs[0];

`ifdef NRF_SLV_ERR_CNT_EN
  logic [8:0] err_inc, err_sum;
  assign err_inc = 9'(csn_rise && state_q == S_IGNORE)
                 + 9'(csn_rise && state_q != S_IDLE && bit_cnt != 3'd0);
  assign err_sum = {1'b0, err_cnt} + err_inc;

  always_ff @(posedge clk_50) begin
    if (!rst)             err_cnt <= 8'h00;
    else if (err_sum[8])  err_cnt <= 8'hFF;
    else                  err_cnt <= err_sum[7:0];
  end
`endif

endmodule

// File: tb/tb_nrf_spi_slave.sv
// Directed bench for nrf_spi_slave: table of SPI transactions plus hand-written abort/collision/reset sequences.
module tb_nrf_spi_slave;
  logic       clk_50 = 1'b0, rst = 1'b0;
  logic       sck = 1'b0, csn = 1'b1, mosi = 1'b0, ce = 1'b0;
  logic [7:0] rx_load = 8'h00;
  logic       rx_load_en = 1'b0;
  logic       miso, miso_oe, payload_valid, busy;
  logic [7:0] payload_out, cfg_out;
`ifdef NRF_SLV_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  nrf_spi_slave dut (
    .clk_50(clk_50), .rst(rst), .sck(sck), .csn(csn), .mosi(mosi), .ce(ce),
    .miso(miso), .miso_oe(miso_oe), .rx_load(rx_load), .rx_load_en(rx_load_en),
    .payload_out(payload_out), .payload_valid(payload_valid), .cfg_out(cfg_out),
`ifdef NRF_SLV_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  always #10 clk_50 = ~clk_50;

  int tests = 0, fails = 0, pv_cnt = 0;

  always @(negedge clk_50) if (payload_valid === 1'b1) pv_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_err(input string name, input int exp);
`ifdef NRF_SLV_ERR_CNT_EN
    check(name, {24'h0, err_cnt}, exp);
`endif
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit collide, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      clks(5);
      rx[i] = miso;
      sck = 1'b1;
      if (collide && i == 0) begin
        clks(1); rx_load_en = 1'b1;
        clks(1); rx_load_en = 1'b0;
        clks(3);
      end else begin
        clks(5);
      end
      sck = 1'b0;
    end
  endtask

  task automatic xfer(input int nb, input logic [7:0] b0, input logic [7:0] b1,
                      output logic [7:0] r0, output logic [7:0] r1);
    csn = 1'b0;
    clks(8);
    check("miso_oe low-csn", miso_oe, 1);
    check("busy in transaction", busy, 1);
    spi_byte(b0, 8, 1'b0, r0);
    r1 = 8'h00;
    if (nb > 1) spi_byte(b1, 8, 1'b0, r1);
    clks(5);
    csn = 1'b1;
    clks(8);
    check("busy after csn high", busy, 0);
    check("miso_oe after csn high", miso_oe, 0);
    check("miso after csn high", miso, 0);
  endtask

  task automatic strobe_rx(input logic [7:0] v);
    rx_load = v;
    rx_load_en = 1'b1;
    clks(1);
    rx_load_en = 1'b0;
    clks(2);
  endtask

  typedef struct {
    string      name;
    bit         rx_pre;
    logic [7:0] rx_val;
    bit         ce_v;
    int         nb;
    logic [7:0] b0, b1;
    logic [7:0] e0, e1;
    bit         chk1;
    logic [7:0] ecfg;
    int         epv;
    logic [7:0] epay;
    int         eerr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] r0, r1;
    int pv0;

    //                name           rx  rxv    ce nb b0     b1     e0     e1     c1 cfg    pv pay    err
    vecs.push_back('{"nop_reset",    0, 8'h00, 0, 2, 8'hFF, 8'hAA, 8'h0E, 8'h00, 0, 8'h00, 0, 8'h00, 0});
    vecs.push_back('{"wreg0",        0, 8'h00, 0, 2, 8'h20, 8'h5A, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h00, 0});
    vecs.push_back('{"rreg0",        0, 8'h00, 0, 2, 8'h00, 8'h00, 8'h0E, 8'h5A, 1, 8'h5A, 0, 8'h00, 0});
    vecs.push_back('{"wtx_ce1",      0, 8'h00, 1, 2, 8'hA0, 8'h3C, 8'h0E, 8'h00, 0, 8'h5A, 1, 8'h3C, 0});
    vecs.push_back('{"nop_txds",     0, 8'h00, 1, 2, 8'hFF, 8'h00, 8'h2E, 8'h00, 0, 8'h5A, 0, 8'h3C, 0});
    vecs.push_back('{"wtx_ce0",      0, 8'h00, 0, 2, 8'hA0, 8'h77, 8'h2E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"w1c_txds",     0, 8'h00, 0, 2, 8'h27, 8'h20, 8'h2E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"nop_cleared",  0, 8'h00, 0, 2, 8'hFF, 8'h00, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"wstatus_ro",   0, 8'h00, 0, 2, 8'h27, 8'hFF, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"rreg_status",  0, 8'h00, 0, 2, 8'h07, 8'h00, 8'h0E, 8'h0E, 1, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"wreg_oob",     0, 8'h00, 0, 2, 8'h2F, 8'h99, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"rreg_oob",     0, 8'h00, 0, 2, 8'h0F, 8'h00, 8'h0E, 8'h00, 1, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"wreg2",        0, 8'h00, 0, 2, 8'h22, 8'h11, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"rreg2",        0, 8'h00, 0, 2, 8'h02, 8'h00, 8'h0E, 8'h11, 1, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"rrx_c3",       1, 8'hC3, 0, 2, 8'h61, 8'h00, 8'h4E, 8'hC3, 1, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"nop_rxclr",    0, 8'h00, 0, 2, 8'hFF, 8'h00, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"rrx_nodata",   1, 8'hA5, 0, 1, 8'h61, 8'h00, 8'h4E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"nop_rxkept",   0, 8'h00, 0, 2, 8'hFF, 8'h00, 8'h4E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"rrx_a5",       0, 8'h00, 0, 2, 8'h61, 8'h00, 8'h4E, 8'hA5, 1, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"nop_rxclr2",   0, 8'h00, 0, 2, 8'hFF, 8'h00, 8'h0E, 8'h00, 0, 8'h5A, 0, 8'h77, 0});
    vecs.push_back('{"ignore_cmd",   0, 8'h00, 0, 2, 8'h50, 8'hFF, 8'h0E, 8'h00, 1, 8'h5A, 0, 8'h77, 1});

    rst = 1'b0;
    clks(5);
    rst = 1'b1;
    clks(3);
    check("reset miso", miso, 0);
    check("reset miso_oe", miso_oe, 0);
    check("reset busy", busy, 0);
    check("reset cfg_out", cfg_out, 8'h00);
    check("reset payload_out", payload_out, 8'h00);
    check("reset payload_valid", payload_valid, 0);
    check_err("reset err_cnt", 0);

    foreach (vecs[k]) begin
      ce = vecs[k].ce_v;
      clks(4);
      if (vecs[k].rx_pre) strobe_rx(vecs[k].rx_val);
      pv0 = pv_cnt;
      xfer(vecs[k].nb, vecs[k].b0, vecs[k].b1, r0, r1);
      check({vecs[k].name, " status byte"}, r0, vecs[k].e0);
      if (vecs[k].chk1) check({vecs[k].name, " data byte"}, r1, vecs[k].e1);
      check({vecs[k].name, " cfg_out"}, cfg_out, vecs[k].ecfg);
      check({vecs[k].name, " payload_valid pulses"}, pv_cnt - pv0, vecs[k].epv);
      check({vecs[k].name, " payload_out"}, payload_out, vecs[k].epay);
      check_err({vecs[k].name, " err_cnt"}, vecs[k].eerr);
    end

    // Abort: W_REGISTER 0x21 with only 4 data bits clocked.
    csn = 1'b0;
    clks(8);
    spi_byte(8'h21, 8, 1'b0, r0);
    spi_byte(8'hA7, 4, 1'b0, r1);
    clks(5);
    csn = 1'b1;
    clks(8);
    check("abort busy", busy, 0);
    check_err("abort err_cnt", 2);
    xfer(2, 8'h01, 8'h00, r0, r1);
    check("abort reg1 unchanged", r1, 8'h00);

    // Collision: rx_load_en lands on the W1C of RX_DR.
    strobe_rx(8'h11);
    rx_load = 8'h96;
    csn = 1'b0;
    clks(8);
    spi_byte(8'h27, 8, 1'b0, r0);
    spi_byte(8'h40, 8, 1'b1, r1);
    clks(5);
    csn = 1'b1;
    clks(8);
    xfer(2, 8'hFF, 8'h00, r0, r1);
    check("collision RX_DR kept", r0, 8'h4E);
    xfer(2, 8'h61, 8'h00, r0, r1);
    check("collision rx buffer", r1, 8'h96);
    xfer(2, 8'hFF, 8'h00, r0, r1);
    check("collision then cleared", r0, 8'h0E);

    // Reset in the middle of a W_REGISTER data byte.
    ce = 1'b0;
    xfer(2, 8'hA0, 8'h42, r0, r1);
    check("pre-reset payload", payload_out, 8'h42);
    csn = 1'b0;
    clks(8);
    spi_byte(8'h23, 8, 1'b0, r0);
    spi_byte(8'h55, 7, 1'b0, r1);
    rst = 1'b0;
    csn = 1'b1;
    clks(3);
    rst = 1'b1;
    clks(3);
    check("midreset busy", busy, 0);
    check("midreset cfg_out", cfg_out, 8'h00);
    check("midreset payload_out", payload_out, 8'h00);
    check_err("midreset err_cnt", 0);
    xfer(2, 8'h03, 8'h00, r0, r1);
    check("midreset status", r0, 8'h0E);
    check("midreset reg3", r1, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nrf_spi_slave.md
Name: nrf_spi_slave

Overview:
SPI responder that emulates the nRF24L01 command and register interface on the far side of the link driven by our SPI controller. It samples the master's sck/csn/mosi on the 50 MHz system clock, decodes nRF-style commands, maintains a small register file and STATUS register, and drives miso. It is used for on-board loopback and bench testing of the controller without physical radio modules attached.

Parameters:
NUM_REGS, 8, implemented register addresses 0..NUM_REGS-1, each 8 bits
STATUS_ADDR, 7, address of the STATUS register; must be < NUM_REGS
SYNC_STAGES, 2, flip-flop stages on sck/csn/mosi inputs; minimum 2

Ports:
clk_50  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-low
sck  in  1  SPI clock from master, asynchronous
csn  in  1  chip select, active-low, asynchronous
mosi  in  1  master-out data, asynchronous
ce  in  1  chip enable; synchronized, gates payload_valid
miso  out  1  slave-out data
miso_oe  out  1  1 while synchronized csn is low; top level tristates miso with it
rx_load  in  8  byte to place in the RX payload buffer
rx_load_en  in  1  one-cycle strobe that loads rx_load
payload_out  out  8  last byte written with W_TX_PAYLOAD
payload_valid  out  1  one-cycle pulse when payload_out updates
cfg_out  out  8  contents of register 0x00
busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Reset (rst low at a clk_50 edge): all registers 0x00 except STATUS = 0x0E; rx buffer 0x00; miso 0; miso_oe 0; payload_out 0x00; payload_valid 0; busy 0; FSM IDLE. Reset mid-transaction aborts it with no register writes.
- SPI mode 0, MSB first. mosi sampled on the synchronized sck rising edge; miso updated on the falling edge. Edge detection compares the last two sync stages.
- Supported sck frequency: ≤ clk_50/8 (6.25 MHz). csn fall to first sck rise must be ≥ 4 clk_50 cycles.
- On csn falling edge: load shift-out register with STATUS; miso = STATUS[7] within SYNC_STAGES+1 cycles; bit counter = 0; FSM CMD.
- The bit counter is 3 bits. A byte completes on the 8th rising edge and the counter wraps to 0.
- FSM states: IDLE, CMD, DATA, IGNORE.
  - IDLE -> CMD on csn fall.
  - CMD -> DATA for a recognised command, or -> IGNORE otherwise, at command byte completion.
  - Any state -> IDLE on csn rise.
- Command decode:
  - 000aaaaa R_REGISTER: every subsequent byte shifts out reg[a], or 0x00 if a ≥ NUM_REGS.
  - 001aaaaa W_REGISTER: the first data byte is written to reg[a] at its completion. Extra bytes are ignored. a ≥ NUM_REGS is ignored.
  - W_REGISTER to STATUS: bits 6:4 are write-1-to-clear; other bits are read-only.
  - 0xA0 W_TX_PAYLOAD: the first data byte goes to payload_out. payload_valid pulses one cycle if ce is high. STATUS[5] (TX_DS) is set. Extra bytes are ignored.
  - 0x61 R_RX_PAYLOAD: data bytes shift out the rx buffer. STATUS[6] (RX_DR) clears at csn rise if ≥1 full data byte was clocked.
  - 0xFF NOP: STATUS only; the FSM goes to DATA and discards data bytes.
  - IGNORE state: miso = 0, no side effects.
- rx_load_en: loads the rx buffer and sets RX_DR. This works in any state. If it coincides with an RX_DR clear (W1C or R_RX_PAYLOAD), the set wins.
- csn rise mid-byte: the partial byte is discarded with no write, and the FSM goes to IDLE. Completed bytes of that transaction keep their effects.
- miso = 0 while csn is high. miso_oe follows synchronized csn, inverted.

Optional Feature:
Macro NRF_SLV_ERR_CNT_EN.
- Defined: adds output err_cnt [7:0], reset 0x00. It increments once per transaction that ends in IGNORE and once per csn rise with a partial byte. It saturates at 0xFF.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then csn low + NOP (0xFF) -> miso byte = 0x0E, mosi ignored, busy 0 after csn high.
- W_REGISTER 0x20 + 0x5A, then R_REGISTER 0x00 + dummy -> second miso byte 0x5A; cfg_out = 0x5A.
- ce=1, W_TX_PAYLOAD 0xA0 + 0x3C -> payload_out 0x3C, payload_valid one pulse, subsequent STATUS read = 0x2E. Repeat with ce=0 -> no pulse.
- rx_load=0xC3 strobe, then R_RX_PAYLOAD 0x61 + dummy -> STATUS 0x4E returned first, then 0xC3; the next NOP returns 0x0E.
- Abort: W_REGISTER 0x21 then csn high after 4 data bits -> reg 1 unchanged (0x00); err_cnt = 1 when the macro is defined.
- Collision: rx_load_en on the same clk_50 cycle as the W1C of 0x40 to STATUS -> RX_DR remains 1.
